// File: rtl/instr_fetch_queue_if.sv
// Fetch/issue-side bundle for instr_fetch_queue. The master drives pushes,
// pops and flush. The queue (slave) returns the issue pair and its status.
interface instr_fetch_queue_if #(
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH) + 1
);
    logic             flush;
    logic             push_valid;
    logic [31:0]      push_instr;
    logic             push_ready;
    logic [31:0]      instr1;
    logic [31:0]      instr2;
    logic             instr1_valid;
    logic             instr2_valid;
    logic [1:0]       pop_cnt;
    logic [CNT_W-1:0] count;
    logic             underflow_err;

    modport master (
        output flush, push_valid, push_instr, pop_cnt,
        input  push_ready, instr1, instr2, instr1_valid, instr2_valid,
               count, underflow_err
    );

    modport slave (
        input  flush, push_valid, push_instr, pop_cnt,
        output push_ready, instr1, instr2, instr1_valid, instr2_valid,
               count, underflow_err
    );
endinterface

// File: rtl/instr_fetch_queue.sv
// Circular instruction buffer between fetch and a dual-issue stage: one push
// per cycle, 0..2 retires per cycle, flush for redirects.
module instr_fetch_queue #(
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                Clk,
    input  logic                Rst_n,
    instr_fetch_queue_if.slave  bus
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [31:0]      r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_underflow;

    logic             w_push_ready;
    logic             w_push_acc;
    logic [1:0]       w_eff_pop;
    logic             w_uflow_set;
    logic [PTR_W-1:0] w_rd_ptr_p1;
    logic [CNT_W-1:0] w_count_nxt;
    logic [31:0]      w_instr1;
    logic [31:0]      w_instr2;
    logic             w_instr1_valid;
    logic             w_instr2_valid;

    // A request of 3 retires as 2; never retire more than is held.
    function automatic logic [1:0] f_eff_pop(input logic [1:0]       pop_req,
                                             input logic [CNT_W-1:0] cnt);
        logic [1:0] req;
        req = (pop_req == 2'd3) ? 2'd2 : pop_req;
        if (cnt < CNT_W'(req)) begin
            f_eff_pop = cnt[1:0];
        end else begin
            f_eff_pop = req;
        end
    endfunction

    function automatic logic f_pop_illegal(input logic [1:0]       pop_req,
                                           input logic [CNT_W-1:0] cnt);
        f_pop_illegal = (pop_req == 2'd3) || (CNT_W'(pop_req) > cnt);
    endfunction

    // Handshake and bookkeeping terms derived from registered state and inputs
    always_comb begin
        w_push_ready = (r_count < CNT_W'(DEPTH));
        w_push_acc   = bus.push_valid && w_push_ready && !bus.flush;
        w_eff_pop    = f_eff_pop(bus.pop_cnt, r_count);
        w_uflow_set  = f_pop_illegal(bus.pop_cnt, r_count);
        w_rd_ptr_p1  = r_rd_ptr + PTR_W'(1);
        w_count_nxt  = r_count + CNT_W'(w_push_acc) - CNT_W'(w_eff_pop);
    end

    // Storage array; contents are never reset since reads are gated by count
    always_ff @(posedge Clk) begin
        if (w_push_acc) begin
            r_mem[r_wr_ptr] <= bus.push_instr;
        end else begin
            r_mem[r_wr_ptr] <= r_mem[r_wr_ptr];
        end
    end

    // Pointers, occupancy and sticky underflow; flush outranks push and pop
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_underflow <= 1'b0;
        end else if (bus.flush) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_underflow <= 1'b0;
        end else begin
            r_wr_ptr    <= r_wr_ptr + PTR_W'(w_push_acc);
            r_rd_ptr    <= r_rd_ptr + PTR_W'(w_eff_pop);
            r_count     <= w_count_nxt;
            r_underflow <= r_underflow | w_uflow_set;
        end
    end

    // Issue pair, zeroed (bubble) when the slot is empty
    always_comb begin
        w_instr1_valid = (r_count >= CNT_W'(1));
        w_instr2_valid = (r_count >= CNT_W'(2));
        if (w_instr1_valid) begin
            w_instr1 = r_mem[r_rd_ptr];
        end else begin
            w_instr1 = 32'h0000_0000;
        end
        if (w_instr2_valid) begin
            w_instr2 = r_mem[w_rd_ptr_p1];
        end else begin
            w_instr2 = 32'h0000_0000;
        end
    end

    assign bus.push_ready    = w_push_ready;
    assign bus.instr1        = w_instr1;
    assign bus.instr2        = w_instr2;
    assign bus.instr1_valid  = w_instr1_valid;
    assign bus.instr2_valid  = w_instr2_valid;
    assign bus.count         = r_count;
    assign bus.underflow_err = r_underflow;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Self-checking bench for instr_fetch_queue: directed scenarios with literal
// expectations, then randomized traffic against a queue-based model.
module tb_instr_fetch_queue;

    localparam int DEPTH = 8;

    logic Clk;
    logic Rst_n;

    instr_fetch_queue_if #(.DEPTH(DEPTH)) bus ();

    instr_fetch_queue #(.DEPTH(DEPTH)) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] mq[$];
    bit          m_uf;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Reference: a plain FIFO of words; pops first, then the push lands at the tail.
    task automatic model_step(input bit fl, input bit pv, input logic [31:0] d,
                              input logic [1:0] pc);
        int sz;
        int req;
        int eff;
        bit acc;
        sz = mq.size();
        if (fl) begin
            mq.delete();
            m_uf = 1'b0;
        end else begin
            req = (pc == 2'd3) ? 2 : int'(pc);
            if (pc == 2'd3 || int'(pc) > sz) m_uf = 1'b1;
            eff = (req < sz) ? req : sz;
            acc = pv && (sz < DEPTH);
            repeat (eff) void'(mq.pop_front());
            if (acc) mq.push_back(d);
        end
    endtask

    task automatic cmp_model();
        int sz;
        sz = mq.size();
        chk("count",         32'(bus.count),    32'(sz));
        chk("push_ready",    32'(bus.push_ready), 32'(sz < DEPTH));
        chk("instr1",        bus.instr1,        (sz >= 1) ? mq[0] : 32'h0);
        chk("instr2",        bus.instr2,        (sz >= 2) ? mq[1] : 32'h0);
        chk("instr1_valid",  32'(bus.instr1_valid), 32'(sz >= 1));
        chk("instr2_valid",  32'(bus.instr2_valid), 32'(sz >= 2));
        chk("underflow_err", 32'(bus.underflow_err), 32'(m_uf));
    endtask

    // One clock: drive at negedge, model at posedge, compare at next negedge.
    task automatic cycle(input bit fl, input bit pv, input logic [31:0] d,
                         input logic [1:0] pc);
        bus.flush      = fl;
        bus.push_valid = pv;
        bus.push_instr = d;
        bus.pop_cnt    = pc;
        @(posedge Clk);
        model_step(fl, pv, d, pc);
        @(negedge Clk);
        cmp_model();
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 32'h0, 2'd0);
    endtask

    initial begin
        bit          fl;
        bit          pv;
        logic [31:0] d;
        logic [1:0]  pc;
        int          r;

        bus.flush      = 1'b0;
        bus.push_valid = 1'b0;
        bus.push_instr = 32'h0;
        bus.pop_cnt    = 2'd0;
        Rst_n          = 1'b0;
        m_uf           = 1'b0;
        repeat (2) @(negedge Clk);

        chk("rst_count",      32'(bus.count), 32'd0);
        chk("rst_push_ready", 32'(bus.push_ready), 32'd1);
        chk("rst_instr1",     bus.instr1, 32'h0);
        chk("rst_instr2",     bus.instr2, 32'h0);
        chk("rst_valid1",     32'(bus.instr1_valid), 32'd0);
        chk("rst_underflow",  32'(bus.underflow_err), 32'd0);
        Rst_n = 1'b1;

        // Three consecutive pushes
        cycle(1'b0, 1'b1, 32'h0000_0013, 2'd0);
        chk("p1_instr1", bus.instr1, 32'h0000_0013);
        chk("p1_instr2", bus.instr2, 32'h0);
        cycle(1'b0, 1'b1, 32'h0010_0093, 2'd0);
        chk("p2_instr2", bus.instr2, 32'h0010_0093);
        cycle(1'b0, 1'b1, 32'h0020_0113, 2'd0);
        chk("p3_count",  32'(bus.count), 32'd3);
        chk("p3_instr1", bus.instr1, 32'h0000_0013);
        chk("p3_instr2", bus.instr2, 32'h0010_0093);
        cycle(1'b1, 1'b0, 32'h0, 2'd0);

        // Fill to full with push_valid held; the 9th value must be dropped
        for (int i = 1; i <= 9; i++) cycle(1'b0, 1'b1, 32'(i), 2'd0);
        chk("full_count", 32'(bus.count), 32'd8);
        chk("full_ready", 32'(bus.push_ready), 32'd0);
        for (int k = 1; k <= 4; k++) begin
            chk("drain_instr1", bus.instr1, 32'(2 * k - 1));
            chk("drain_instr2", bus.instr2, 32'(2 * k));
            cycle(1'b0, 1'b0, 32'h0, 2'd2);
        end
        chk("drain_count",  32'(bus.count), 32'd0);
        chk("drain_instr1", bus.instr1, 32'h0);

        // Wrap: read pointer ends at 6, pair spans entries 6,7 then 0
        cycle(1'b1, 1'b0, 32'h0, 2'd0);
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 32'h100 + 32'(i), 2'd0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'h0, 2'd2);
        cycle(1'b0, 1'b1, 32'hA, 2'd0);
        cycle(1'b0, 1'b1, 32'hB, 2'd0);
        cycle(1'b0, 1'b1, 32'hC, 2'd0);
        chk("wrap_instr1", bus.instr1, 32'hA);
        chk("wrap_instr2", bus.instr2, 32'hB);
        cycle(1'b0, 1'b0, 32'h0, 2'd2);
        chk("wrap2_instr1", bus.instr1, 32'hC);
        chk("wrap2_instr2", bus.instr2, 32'h0);
        chk("wrap2_valid2", 32'(bus.instr2_valid), 32'd0);

        // Over-pop at count 1: sticky error, cleared by flush
        cycle(1'b0, 1'b0, 32'h0, 2'd2);
        chk("uf_count", 32'(bus.count), 32'd0);
        chk("uf_set",   32'(bus.underflow_err), 32'd1);
        idle();
        idle();
        chk("uf_sticky", 32'(bus.underflow_err), 32'd1);
        cycle(1'b1, 1'b0, 32'h0, 2'd0);
        chk("uf_clear", 32'(bus.underflow_err), 32'd0);

        // Count 1, pop 1 plus push: count holds, new word at the head
        cycle(1'b0, 1'b1, 32'h11, 2'd0);
        cycle(1'b0, 1'b1, 32'h22, 2'd1);
        chk("swap_count",  32'(bus.count), 32'd1);
        chk("swap_instr1", bus.instr1, 32'h22);
        cycle(1'b1, 1'b0, 32'h0, 2'd0);

        // Flush beats a concurrent push and pop
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 32'h200 + 32'(i), 2'd0);
        cycle(1'b1, 1'b1, 32'hDEAD_BEEF, 2'd1);
        chk("flush_count",  32'(bus.count), 32'd0);
        chk("flush_instr1", bus.instr1, 32'h0);
        chk("flush_instr2", bus.instr2, 32'h0);
        idle();
        chk("flush_nopush", 32'(bus.count), 32'd0);

        // Asynchronous reset mid-cycle with four entries held
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 32'h300 + 32'(i), 2'd0);
        #2;
        Rst_n = 1'b0;
        #1;
        chk("arst_count",  32'(bus.count), 32'd0);
        chk("arst_valid1", 32'(bus.instr1_valid), 32'd0);
        chk("arst_ready",  32'(bus.push_ready), 32'd1);
        mq.delete();
        m_uf = 1'b0;
        @(negedge Clk);
        Rst_n = 1'b1;

        // Randomized traffic alternating fill-biased and drain-biased phases
        for (int i = 0; i < 3000; i++) begin
            fl = ($urandom_range(0, 39) == 0);
            d  = $urandom;
            r  = $urandom_range(0, 15);
            if (((i / 150) % 2) == 0) begin
                pv = ($urandom_range(0, 9) != 0);
                pc = (r == 0) ? 2'd3 : (r < 9) ? 2'd0 : (r < 14) ? 2'd1 : 2'd2;
            end else begin
                pv = ($urandom_range(0, 3) != 0);
                pc = (r == 0) ? 2'd3 : (r < 4) ? 2'd0 : (r < 9) ? 2'd1 : 2'd2;
            end
            cycle(fl, pv, d, pc);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
